// File: rtl/ksa_swap_fsm_pkg.sv
// ksa_swap_fsm_pkg: shared RC4 types, sizes and KSA state encoding
package ksa_swap_fsm_pkg;
  localparam int KEY_LENGTH = 3;
  localparam int KEY_WIDTH = 8 * KEY_LENGTH;
  localparam int MEM_DEPTH = 256;
  localparam int KI_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  typedef logic [7:0] byte_t;
  typedef logic [KI_W-1:0] key_idx_t;
  typedef enum logic [3:0] {
    IDLE, RD_I, WT_I, LAT_I, RD_J, WT_J, LAT_J, WR_I, WR_J, NEXT, DONE
  } ksa_state_t;
endpackage

// File: rtl/ksa_swap_fsm_key_sel.sv
// ksa_key_sel: picks key byte k from the latched key, byte 0 in the MSBs
module ksa_key_sel
  import ksa_swap_fsm_pkg::*;
(
  input  logic [KEY_WIDTH-1:0] key,
  input  key_idx_t             k,
  output byte_t                keybyte
);
  always_comb begin
    keybyte = '0;
    for (int n = 0; n < KEY_LENGTH; n++)
      if (k == key_idx_t'(n)) keybyte = key[KEY_WIDTH-1-8*n -: 8];
  end
endmodule

// File: rtl/ksa_swap_fsm.sv
// ksa_swap_fsm: RC4 key-scheduling swap pass over a single-port 256x8 S-memory
module ksa_swap_fsm
  import ksa_swap_fsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_ksa,
  input  logic [KEY_WIDTH-1:0] secret_key,
  input  logic [7:0]           q,
  output logic [7:0]           address,
  output logic [7:0]           data,
  output logic                 wren,
  output logic                 finish
);
  ksa_state_t state;
  byte_t i, j, si, kb, jn;
  key_idx_t k;
  logic [KEY_WIDTH-1:0] key_l;
  ksa_key_sel u_key_sel (.key(key_l), .k(k), .keybyte(kb));
  assign jn = j + q + kb;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      k <= '0;
      si <= '0;
      key_l <= '0;
      address <= '0;
      data <= '0;
      wren <= 1'b0;
      finish <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE:
          if (start_ksa) begin
            key_l <= secret_key;
            i <= '0;
            j <= '0;
            k <= '0;
            address <= '0;
            wren <= 1'b0;
            finish <= 1'b0;
            state <= RD_I;
          end else finish <= (state == DONE);
        RD_I: state <= WT_I;
        WT_I: state <= LAT_I;
        LAT_I: begin
          si <= q;
          j <= jn;
          address <= jn;
          state <= RD_J;
        end
        RD_J: state <= WT_J;
        WT_J: state <= LAT_J;
        LAT_J: begin
          address <= i;
          data <= q;
          wren <= 1'b1;
          state <= WR_I;
        end
        WR_I: begin
          address <= j;
          data <= si;
          state <= WR_J;
        end
        WR_J: begin
          wren <= 1'b0;
          state <= NEXT;
        end
        NEXT:
          if (i == byte_t'(MEM_DEPTH - 1)) state <= DONE;
          else begin
            i <= i + 8'd1;
            k <= (k == key_idx_t'(KEY_LENGTH - 1)) ? '0 : k + 1'b1;
            address <= i + 8'd1;
            state <= RD_I;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ksa_swap_fsm.sv
// tb_ksa_swap_fsm: scoreboarded KSA runs against a 1-cycle-latency memory model
module tb_ksa_swap_fsm;
  logic clk = 0, reset_n = 0, start_ksa = 0, init = 0, chk = 1;
  logic [23:0] secret_key = '0;
  logic [7:0] q, address, data;
  logic wren, finish;
  logic [7:0] mem [256];
  logic [7:0] gold [256];
  logic [15:0] exp_q [$];
  int n_vec = 0, n_err = 0;

  ksa_swap_fsm dut (.clk(clk), .reset_n(reset_n), .start_ksa(start_ksa), .secret_key(secret_key),
                    .q(q), .address(address), .data(data), .wren(wren), .finish(finish));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init) for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
    else if (wren) mem[address] <= data;
    q <= mem[address];
  end

  always @(negedge clk)
    if (chk && wren) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write addr=%02h data=%02h", address, data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({address, data} !== e) begin
          n_err++;
          $display("FAIL write addr/data got=%02h/%02h exp=%02h/%02h", address, data, e[15:8], e[7:0]);
        end
      end
    end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic init_mem();
    init = 1;
    @(posedge clk);
    #1 init = 0;
  endtask

  task automatic run(input logic [23:0] key, input bit mid_pulse);
    logic [7:0] jj, t;
    int n, bad;
    bit seen [256];
    for (int x = 0; x < 256; x++) gold[x] = mem[x];
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = jj + gold[x] + key[23-8*(x%3) -: 8];
      exp_q.push_back({8'(x), gold[jj]});
      exp_q.push_back({jj, gold[x]});
      t = gold[x];
      gold[x] = gold[jj];
      gold[jj] = t;
    end
    secret_key = key;
    start_ksa = 1;
    @(posedge clk);
    #1 start_ksa = 0;
    check("finish_after_accept", finish, 0);
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      start_ksa = mid_pulse && (n == 100);
      if (finish) break;
    end
    start_ksa = 0;
    check("finish_latency", n, 2305);
    check("writes_outstanding", exp_q.size(), 0);
    exp_q.delete();
    bad = 0;
    for (int x = 0; x < 256; x++) if (mem[x] !== gold[x]) bad++;
    check("mem_vs_golden", bad, 0);
    bad = 0;
    for (int x = 0; x < 256; x++) seen[x] = 0;
    for (int x = 0; x < 256; x++) seen[mem[x]] = 1;
    for (int x = 0; x < 256; x++) if (!seen[x]) bad++;
    check("mem_permutation", bad, 0);
    repeat (3) @(posedge clk);
    #1 check("finish_held", finish, 1);
    check("wren_in_done", wren, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_address", address, 0);
    check("rst_data", data, 0);
    check("rst_wren", wren, 0);
    check("rst_finish", finish, 0);
    reset_n = 1;
    init_mem();
    repeat (2) @(posedge clk);
    #1 check("idle_finish", finish, 0);
    run(24'h010203, 0);
    init_mem();
    run(24'h000000, 0);
    init_mem();
    run(24'h3C5A96, 1);
    init_mem();
    chk = 0;
    secret_key = 24'hA1B2C3;
    start_ksa = 1;
    @(posedge clk);
    #1 start_ksa = 0;
    repeat (500) @(posedge clk);
    #1 reset_n = 0;
    @(posedge clk);
    #1;
    check("midrst_wren", wren, 0);
    check("midrst_finish", finish, 0);
    check("midrst_address", address, 0);
    reset_n = 1;
    repeat (3) @(posedge clk);
    #1 check("midrst_quiet", wren, 0);
    chk = 1;
    run(24'hA1B2C3, 0);
    run(24'hFFFFFF, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
